// File: rtl/writeback_unit_pkg.sv
// rtl/writeback_unit_pkg.sv - shared writeback constants and types
package writeback_unit_pkg;

    localparam int WB_WIDTH = 32;

    localparam int RD_WE     = 0;
    localparam int SEL_MEM   = 1;
    localparam int STATUS_WE = 2;

    localparam int STATUS_REG = 30;

    typedef struct packed {
        logic                valid;
        logic [4:0]          addr;
        logic [WB_WIDTH-1:0] data;
    } wr_req_t;

    typedef enum logic {
        PB_IDLE,
        PB_PENDING
    } pb_state_t;

endpackage

// File: rtl/wb_pending_buf.sv
// rtl/wb_pending_buf.sv - one-entry mult/div result buffer with drop logic
module wb_pending_buf (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   lat_valid,
    input  logic [4:0]                             lat_addr,
    input  logic                                   md_ready,
    input  logic [4:0]                             md_rd,
    input  logic [writeback_unit_pkg::WB_WIDTH-1:0] md_result,
    output writeback_unit_pkg::wr_req_t            md_wr,
    output logic                                   md_drop_pulse,
    output logic                                   md_stall
);
    import writeback_unit_pkg::*;

    pb_state_t state_q, state_d;
    wr_req_t   buf_q, buf_d;
    logic      md_new;

    assign md_new   = md_ready && (md_rd != 5'd0);
    assign md_stall = (state_q == PB_PENDING);

    // Next state: the latch path always owns the port; mult/div waits or yields to a younger write
    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        md_wr         = '0;
        md_drop_pulse = 1'b0;
        case (state_q)
            PB_IDLE: begin
                if (md_new) begin
                    if (!lat_valid) begin
                        md_wr = '{valid: 1'b1, addr: md_rd, data: md_result};
                    end else if (lat_addr == md_rd) begin
                        md_drop_pulse = 1'b1;
                    end else begin
                        buf_d   = '{valid: 1'b1, addr: md_rd, data: md_result};
                        state_d = PB_PENDING;
                    end
                end
            end
            PB_PENDING: begin
                // A second result while one is outstanding is discarded; the older entry survives
                if (md_new) begin
                    md_drop_pulse = 1'b1;
                end
                if (!lat_valid) begin
                    md_wr   = buf_q;
                    buf_d   = '0;
                    state_d = PB_IDLE;
                end else if (lat_addr == buf_q.addr) begin
                    md_drop_pulse = 1'b1;
                    buf_d         = '0;
                    state_d       = PB_IDLE;
                end
            end
            default: begin
                buf_d   = '0;
                state_d = PB_IDLE;
            end
        endcase
    end

    // State and buffer registers; reset silently discards any pending entry
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= PB_IDLE;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - writeback stage driving the register-file write port
module writeback_unit #(
    parameter int WIDTH      = writeback_unit_pkg::WB_WIDTH,
    parameter int STATUS_REG = writeback_unit_pkg::STATUS_REG
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] wb_ALU_result,
    input  logic [WIDTH-1:0] wb_data_read,
    input  logic [4:0]       wb_rd,
    input  logic [11:0]      wb_ctrl_signals,
    input  logic             md_ready,
    input  logic [WIDTH-1:0] md_result,
    input  logic [4:0]       md_rd,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic             md_stall,
    output logic             md_drop
);
    import writeback_unit_pkg::*;

    wr_req_t          lat_req;
    wr_req_t          md_wr;
    wr_req_t          wr_sel;
    logic             md_drop_pulse;
    logic [8:0]       unused_ctrl;

    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic             md_drop_q, md_drop_d;

    assign unused_ctrl = wb_ctrl_signals[11:3];

    // Latch-path request: a status write overrides the normal destination
    always_comb begin
        lat_req = '0;
        if (wb_ctrl_signals[STATUS_WE]) begin
            lat_req = '{valid: 1'b1, addr: 5'(STATUS_REG), data: wb_ALU_result};
        end else if (wb_ctrl_signals[RD_WE] && (wb_rd != 5'd0)) begin
            lat_req.valid = 1'b1;
            lat_req.addr  = wb_rd;
            lat_req.data  = wb_ctrl_signals[SEL_MEM] ? wb_data_read : wb_ALU_result;
        end
    end

    wb_pending_buf u_pending_buf (
        .clock         (clock),
        .reset         (reset),
        .lat_valid     (lat_req.valid),
        .lat_addr      (lat_req.addr),
        .md_ready      (md_ready),
        .md_rd         (md_rd),
        .md_result     (md_result),
        .md_wr         (md_wr),
        .md_drop_pulse (md_drop_pulse),
        .md_stall      (md_stall)
    );

    // Port arbitration and hold-last-value behaviour of the write address/data
    always_comb begin
        wr_sel     = lat_req.valid ? lat_req : md_wr;
        rf_we_d    = wr_sel.valid;
        rf_waddr_d = wr_sel.valid ? wr_sel.addr : rf_waddr_q;
        rf_wdata_d = wr_sel.valid ? wr_sel.data : rf_wdata_q;
        md_drop_d  = md_drop_pulse;
    end

    // Output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            md_drop_q  <= 1'b0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            md_drop_q  <= md_drop_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign md_drop  = md_drop_q;

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - self-checking bench for writeback_unit
module tb_writeback_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] wb_ALU_result = '0;
    logic [31:0] wb_data_read = '0;
    logic [4:0]  wb_rd = '0;
    logic [11:0] wb_ctrl_signals = '0;
    logic        md_ready = 1'b0;
    logic [31:0] md_result = '0;
    logic [4:0]  md_rd = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        md_stall;
    logic        md_drop;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        pend[$];
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic        exp_stall;
    logic        exp_drop;

    writeback_unit dut (
        .clock           (clock),
        .reset           (reset),
        .wb_ALU_result   (wb_ALU_result),
        .wb_data_read    (wb_data_read),
        .wb_rd           (wb_rd),
        .wb_ctrl_signals (wb_ctrl_signals),
        .md_ready        (md_ready),
        .md_result       (md_result),
        .md_rd           (md_rd),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .md_stall        (md_stall),
        .md_drop         (md_drop)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        pend.delete();
        exp_we = 0; exp_waddr = 0; exp_wdata = 0; exp_stall = 0; exp_drop = 0;
    endtask

    // Reference model: one write port, latch path has priority, at most one waiting mult/div result
    task automatic model_step();
        bit          lv;
        logic [4:0]  la;
        logic [31:0] ld;
        bit          mv;
        logic [4:0]  ma;
        logic [31:0] md;
        lv = 0; la = 0; ld = 0; mv = 0; ma = 0; md = 0;
        exp_drop = 0;
        if (wb_ctrl_signals[2]) begin
            lv = 1; la = 5'd30; ld = wb_ALU_result;
        end else if (wb_ctrl_signals[0] && wb_rd != 0) begin
            lv = 1; la = wb_rd; ld = wb_ctrl_signals[1] ? wb_data_read : wb_ALU_result;
        end
        if (pend.size() != 0) begin
            if (md_ready && md_rd != 0) exp_drop = 1;
            if (!lv) begin
                mv = 1; ma = pend[0].a; md = pend[0].d;
                void'(pend.pop_front());
            end else if (la == pend[0].a) begin
                exp_drop = 1;
                void'(pend.pop_front());
            end
        end else if (md_ready && md_rd != 0) begin
            if (!lv) begin
                mv = 1; ma = md_rd; md = md_result;
            end else if (la == md_rd) begin
                exp_drop = 1;
            end else begin
                pend.push_back('{a: md_rd, d: md_result});
            end
        end
        exp_we = lv || mv;
        if (lv) begin
            exp_waddr = la; exp_wdata = ld;
        end else if (mv) begin
            exp_waddr = ma; exp_wdata = md;
        end
        exp_stall = (pend.size() != 0);
    endtask

    // Apply one cycle of inputs; called at posedge+1, returns at the following posedge+1
    task automatic drive(input logic [11:0] ctrl, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] mem, input logic mdr, input logic [4:0] mdrd,
                         input logic [31:0] mdd);
        wb_ctrl_signals = ctrl; wb_rd = rd; wb_ALU_result = alu; wb_data_read = mem;
        md_ready = mdr; md_rd = mdrd; md_result = mdd;
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        drive(12'h000, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wb_ctrl_signals = '0; md_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, md_stall, md_drop} !== 40'h0) begin
            errors++;
            $display("FAIL reset_state: got we=%b addr=%0d data=%h stall=%b drop=%b, want all 0",
                     rf_we, rf_waddr, rf_wdata, md_stall, md_drop);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_alu_write();
        drive(12'h001, 5'd5, 32'h1234, 32'hFFFF_0000, 1'b0, 5'd0, 32'h0);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
            errors++;
            $display("FAIL alu_write: got we=%b addr=%0d data=%h, want 1 5 00001234", rf_we, rf_waddr, rf_wdata);
        end
        idle();
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
            errors++;
            $display("FAIL alu_hold: got we=%b addr=%0d data=%h, want 0 5 00001234", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_mem_and_r0();
        drive(12'h003, 5'd7, 32'h1111, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL mem_write: got we=%b addr=%0d data=%h, want 1 7 deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        drive(12'h001, 5'd0, 32'h99, 32'h0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL r0_write: got we=%b addr=%0d data=%h, want 0 7 deadbeef", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_status();
        drive(12'h005, 5'd3, 32'h2, 32'h0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd30 || rf_wdata !== 32'h2) begin
            errors++;
            $display("FAIL status_write: got we=%b addr=%0d data=%h, want 1 30 00000002", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_md_pending();
        drive(12'h001, 5'd4, 32'h44, 32'h0, 1'b1, 5'd9, 32'hAA);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h44 || md_stall !== 1'b1) begin
            errors++;
            $display("FAIL md_conflict: got we=%b addr=%0d data=%h stall=%b, want 1 4 00000044 1",
                     rf_we, rf_waddr, rf_wdata, md_stall);
        end
        idle();
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hAA || md_stall !== 1'b0) begin
            errors++;
            $display("FAIL md_drain: got we=%b addr=%0d data=%h stall=%b, want 1 9 000000aa 0",
                     rf_we, rf_waddr, rf_wdata, md_stall);
        end
        drive(12'h000, 5'd0, 32'h0, 32'h0, 1'b1, 5'd12, 32'h77);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h77 || md_stall !== 1'b0) begin
            errors++;
            $display("FAIL md_direct: got we=%b addr=%0d data=%h stall=%b, want 1 12 00000077 0",
                     rf_we, rf_waddr, rf_wdata, md_stall);
        end
        drive(12'h000, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 32'h88);
        checks++;
        if (rf_we !== 1'b0 || md_drop !== 1'b0 || md_stall !== 1'b0) begin
            errors++;
            $display("FAIL md_r0: got we=%b drop=%b stall=%b, want 0 0 0", rf_we, md_drop, md_stall);
        end
    endtask

    task automatic test_md_drop();
        drive(12'h001, 5'd4, 32'h44, 32'h0, 1'b1, 5'd9, 32'hAA);
        drive(12'h001, 5'd9, 32'h55, 32'h0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h55 || md_drop !== 1'b1 || md_stall !== 1'b0) begin
            errors++;
            $display("FAIL pend_drop: got we=%b addr=%0d data=%h drop=%b stall=%b, want 1 9 00000055 1 0",
                     rf_we, rf_waddr, rf_wdata, md_drop, md_stall);
        end
        idle();
        idle();
        checks++;
        if (rf_we !== 1'b0 || md_drop !== 1'b0 || rf_wdata !== 32'h55) begin
            errors++;
            $display("FAIL no_late_write: got we=%b drop=%b data=%h, want 0 0 00000055", rf_we, md_drop, rf_wdata);
        end
        drive(12'h003, 5'd6, 32'h0, 32'h66, 1'b1, 5'd6, 32'hCC);
        checks++;
        if (rf_we !== 1'b1 || rf_wdata !== 32'h66 || md_drop !== 1'b1 || md_stall !== 1'b0) begin
            errors++;
            $display("FAIL idle_same_addr: got we=%b data=%h drop=%b stall=%b, want 1 00000066 1 0",
                     rf_we, rf_wdata, md_drop, md_stall);
        end
        drive(12'h001, 5'd4, 32'h44, 32'h0, 1'b1, 5'd9, 32'hAA);
        drive(12'h001, 5'd5, 32'h50, 32'h0, 1'b1, 5'd11, 32'hBB);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || md_drop !== 1'b1 || md_stall !== 1'b1) begin
            errors++;
            $display("FAIL second_md: got we=%b addr=%0d drop=%b stall=%b, want 1 5 1 1", rf_we, rf_waddr, md_drop, md_stall);
        end
        idle();
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hAA || md_drop !== 1'b0) begin
            errors++;
            $display("FAIL older_kept: got we=%b addr=%0d data=%h drop=%b, want 1 9 000000aa 0",
                     rf_we, rf_waddr, rf_wdata, md_drop);
        end
    endtask

    task automatic test_async_reset();
        drive(12'h001, 5'd4, 32'h44, 32'h0, 1'b1, 5'd9, 32'hAA);
        wb_ctrl_signals = '0; md_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, md_stall, md_drop} !== 40'h0) begin
            errors++;
            $display("FAIL async_reset: got we=%b addr=%0d data=%h stall=%b drop=%b, want all 0",
                     rf_we, rf_waddr, rf_wdata, md_stall, md_drop);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            idle();
            checks++;
            if (rf_we !== 1'b0 || md_drop !== 1'b0 || md_stall !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_quiet[%0d]: got we=%b addr=%0d drop=%b stall=%b, want 0 - 0 0",
                         i, rf_we, rf_waddr, md_drop, md_stall);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] pick [6];
        pick[0] = 5'd0; pick[1] = 5'd1; pick[2] = 5'd2; pick[3] = 5'd3; pick[4] = 5'd30; pick[5] = 5'd17;
        for (int i = 0; i < 400; i++) begin
            drive(12'($urandom) & (($urandom_range(0, 3) == 0) ? 12'hFFF : 12'hFFB),
                  pick[$urandom_range(0, 5)], $urandom, $urandom,
                  ($urandom_range(0, 3) == 0), pick[$urandom_range(0, 5)], $urandom);
            checks++;
            if (rf_we !== exp_we || rf_waddr !== exp_waddr || rf_wdata !== exp_wdata ||
                md_stall !== exp_stall || md_drop !== exp_drop) begin
                errors++;
                $display("FAIL random[%0d]: got we=%b addr=%0d data=%h stall=%b drop=%b, want %b %0d %h %b %b",
                         i, rf_we, rf_waddr, rf_wdata, md_stall, md_drop,
                         exp_we, exp_waddr, exp_wdata, exp_stall, exp_drop);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alu_write();
        test_mem_and_r0();
        test_status();
        test_md_pending();
        test_md_drop();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writeback stage of the five-stage pipeline, consuming the memory/writeback latch outputs and driving the single register-file write port. Selects ALU result or memory read data per control bits, handles status-register (r30) writes, and merges out-of-band results from the multicycle mult/div unit through a one-entry pending buffer. When the buffered result cannot yet be written, it requests a front-end stall.

## Interface

Parameters:
- `WIDTH`, 32: datapath width.
- `STATUS_REG`, 30: register index written on status writes.

Ports:
- `clock`  in  1: rising-edge clock. One clock domain.
- `reset`  in  1: asynchronous, active-high reset.
- `wb_ALU_result`  in  WIDTH: ALU result from the memory/writeback latch.
- `wb_data_read`  in  WIDTH: memory read data from the latch.
- `wb_rd`  in  5: destination register from the latch.
- `wb_ctrl_signals`  in  12: control bits from the latch. Bit 0 is `RD_WE`, bit 1 is `SEL_MEM`, bit 2 is `STATUS_WE`, and bits 11:3 are ignored.
- `md_ready`  in  1: one-cycle pulse, mult/div result valid.
- `md_result`  in  WIDTH: mult/div result.
- `md_rd`  in  5: mult/div destination register.
- `rf_we`  out  1: register-file write enable (registered).
- `rf_waddr`  out  5: write address (registered).
- `rf_wdata`  out  WIDTH: write data (registered).
- `md_stall`  out  1: pending mult/div result awaiting the write port (registered).
- `md_drop`  out  1: one-cycle pulse when a pending or arriving mult/div result is discarded (registered).

## Operation

Latch-path request (combinational, per cycle):
- If `STATUS_WE`=1, the request is address `STATUS_REG` with data `wb_ALU_result`. `RD_WE` is ignored that cycle.
- Otherwise, if `RD_WE`=1 and `wb_rd`≠0, the request is address `wb_rd`. Data is `wb_data_read` if `SEL_MEM`=1, else `wb_ALU_result`.
- Otherwise there is no latch-path request.

Mult/div source:
- The source is the pending buffer if it is valid, else the arriving `md_ready` result.
- An `md_rd` of 0 is discarded silently: no write and no `md_drop`.

Pending buffer states:
- IDLE: buffer empty.
  - `md_ready` with no latch-path request: write the mult/div result directly and stay in IDLE.
  - `md_ready` with a latch-path request: the latch path wins the port. Capture the mult/div result and go to PENDING, unless the latch address equals `md_rd`; in that case discard the result and pulse `md_drop`, because the younger instruction wins.
- PENDING: buffer holds {addr, data}.
  - No latch-path request: write the buffer and go to IDLE.
  - Latch-path request to the buffered address: discard the buffer, pulse `md_drop`, go to IDLE.
  - Latch-path request to a different address: stay in PENDING.
  - `md_ready` while in PENDING is a protocol violation, because the mult/div unit is single-outstanding. The buffer keeps the older entry, the new result is dropped, and `md_drop` pulses.
- `md_stall` = 1 exactly while in PENDING.

Widths: all data is passed through unmodified. No arithmetic is performed.

## Timing

- Latency is one cycle: inputs sampled at edge N appear on `rf_*` after edge N.
- `rf_we` is high for exactly one cycle per accepted write. `rf_waddr` and `rf_wdata` hold their last values when `rf_we`=0.
- `md_stall` rises the cycle after the conflicting edge. It falls the cycle after the buffer drains or is dropped.
- Reset values: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `md_stall`=0, `md_drop`=0, state IDLE, buffer cleared.
- Reset mid-operation discards any pending result without a `md_drop` pulse.
- Address 0 never produces `rf_we`=1.

## Structure

- Shared pipeline package:
  - control-bit index constants `RD_WE`, `SEL_MEM`, `STATUS_WE`;
  - `STATUS_REG`;
  - a typedef for the {valid, addr, data} write-request struct.
- Natural sub-module: `wb_pending_buf`, containing the one-entry buffer, the IDLE/PENDING state machine and the drop logic.
- The top level performs source selection and output registering.

## Test plan

1. Reset, then `RD_WE`=1, `wb_rd`=5, `SEL_MEM`=0, ALU result 0x1234 -> next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x1234.
2. `RD_WE`=1, `SEL_MEM`=1, `wb_rd`=7, data_read 0xDEADBEEF. Separately, `wb_rd`=0 -> first write is 0xDEADBEEF to r7. The r0 case gives `rf_we`=0.
3. `STATUS_WE`=1 and `RD_WE`=1, `wb_rd`=3, ALU 0x2 -> write 0x2 to r30 only.
4. `md_ready` with `md_rd`=9, 0xAA, while the latch writes r4 -> r4 written and `md_stall`=1. On the next idle latch cycle, r9 is written with 0xAA and `md_stall`=0.
5. Pending r9, then a latch write to r9 of 0x55 -> r9=0x55 written, `md_drop` pulses, no later write of 0xAA.
6. Pending r9, assert `reset` asynchronously mid-cycle -> outputs go to 0 immediately. With no further stimulus, no r9 write occurs after reset.
